// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: APB bus between the round-robin master and a single slave.
interface apb_rr_master_if;
   logic [31:0] PADDR;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic        PSEL;
   logic        PENABLE;
   logic [31:0] PRDATA;
   logic        PREADY;
   modport master (output PADDR, PWRITE, PWDATA, PSEL, PENABLE, input PRDATA, PREADY);
   modport slave (input PADDR, PWRITE, PWDATA, PSEL, PENABLE, output PRDATA, PREADY);
endinterface

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester round-robin APB master with address rejection and PREADY timeout.
module apb_rr_master #(
   parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
   parameter int unsigned ADDR_SIZE   = 64,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        m0_req,
   input  logic        m0_write,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_write,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   apb_rr_master_if.master apb
);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
   state_t state, state_nx;
   logic gid, last_grant, err_q, r0, r1, gnt, bad, timeout, sel_write;
   logic [31:0] sel_addr, sel_wdata, offset;
   logic [CW-1:0] wcnt;

   assign r0 = m0_req & ~m0_done;
   assign r1 = m1_req & ~m1_done;
   assign apb.PSEL = state == SETUP || state == ACCESS;
   assign apb.PENABLE = state == ACCESS;
   assign m0_done = state == RESP && !gid;
   assign m1_done = state == RESP && gid;
   assign m0_err = m0_done & err_q;
   assign m1_err = m1_done & err_q;

   // on a tie the requester not granted last wins
   always_comb begin
      gnt = (r0 & r1) ? ~last_grant : r1;
      sel_addr = gnt ? m1_addr : m0_addr;
      sel_write = gnt ? m1_write : m0_write;
      sel_wdata = gnt ? m1_wdata : m0_wdata;
      offset = sel_addr - ADDR_BASE;
      bad = |sel_addr[1:0] || sel_addr < ADDR_BASE || offset >= ADDR_SIZE;
      timeout = !apb.PREADY && wcnt == CW'(TIMEOUT_CYC - 1);
      state_nx = state;
      case (state)
         IDLE:    state_nx = (r0 | r1) ? (bad ? RESP : SETUP) : IDLE;
         SETUP:   state_nx = ACCESS;
         ACCESS:  state_nx = (apb.PREADY || timeout) ? RESP : ACCESS;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else state <= state_nx;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         apb.PADDR <= '0;
         apb.PWRITE <= 1'b0;
         apb.PWDATA <= '0;
         m0_rdata <= '0;
         m1_rdata <= '0;
         gid <= 1'b0;
         err_q <= 1'b0;
         last_grant <= 1'b1;
         wcnt <= '0;
      end else begin
         if (state == IDLE && (r0 | r1)) begin
            gid <= gnt;
            err_q <= bad;
            if (!bad) begin
               apb.PADDR <= sel_addr;
               apb.PWRITE <= sel_write;
               apb.PWDATA <= sel_wdata;
            end
         end
         wcnt <= (state == ACCESS && !apb.PREADY) ? wcnt + CW'(1) : '0;
         if (state == ACCESS) err_q <= timeout;
         if (state == ACCESS && apb.PREADY && !apb.PWRITE && !gid) m0_rdata <= apb.PRDATA;
         if (state == ACCESS && apb.PREADY && !apb.PWRITE && gid) m1_rdata <= apb.PRDATA;
         if (state == RESP) last_grant <= gid;
      end
   end
endmodule
